layer_out_serializer: RTL and testbench
=======================================

Name: layer_out_serializer

Overview:
- Sits between the neuron array of one layer and the next layer's shared input bus.
- Captures the `dataWidth`-bit outputs of `numNeuron` parallel neurons, each qualified by its own valid.
- Once every neuron has reported, streams the values serially, neuron 0 first, on a valid/ready interface.
- The stream drives the next layer's broadcast input/valid pair; with `out_ready` tied high it issues one element per cycle.

Parameters:
- numNeuron, 30: number of neurons in the producing layer (≥1).
- dataWidth, 16: width of each neuron output and of `out_data`.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_data  in  numNeuron*dataWidth  neuron outputs; neuron i occupies bits [i*dataWidth +: dataWidth].
- in_valid  in  numNeuron  per-neuron output-valid, single-cycle pulses.
- out_data  out  dataWidth  serialized element.
- out_valid  out  1  `out_data` valid.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- out_last  out  1  high with `out_valid` on element numNeuron-1.
- busy  out  1  high in SEND state.
- drop_err  out  1  one-cycle pulse: a neuron output arrived in SEND and was discarded.
- dup_err  out  1  one-cycle pulse: a neuron re-reported in COLLECT before the frame completed.

Behaviour:
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `drop_err`=0, `dup_err`=0. Internally, state=COLLECT, capture mask=0, index=0, buffer=0.
- Reset is asynchronous and may assert mid-frame. It aborts the frame; no partial output follows.
- Index counter width: max(1, $clog2(numNeuron)).
- COLLECT state:
  - For each i with `in_valid[i]`=1, buffer[i] <= in_data slice i and mask[i] <= 1. Any subset may be valid in the same cycle.
  - If `in_valid[i]` and mask[i] were already 1, the buffer is overwritten with the new value and `dup_err` pulses the next cycle.
  - When (mask | in_valid) becomes all-ones on an edge, that same edge:
    - clears mask;
    - sets index=0;
    - enters SEND;
    - loads `out_data`=element 0 (taking the value arriving that cycle if applicable) and sets `out_valid`=1.
  - Latency: `out_valid` rises exactly one cycle after the cycle in which the last neuron valid was sampled.
- SEND state:
  - `busy`=1; `out_valid`=1 continuously; `out_data`=buffer[index]; `out_last`=(index==numNeuron-1).
  - Transfer occurs on an edge with `out_valid`&`out_ready`. Without `out_ready`, `out_data`, `out_valid` and `out_last` hold stable.
  - On a transfer with index<numNeuron-1: index++, next element presented the following cycle. No bubble.
  - On a transfer with index==numNeuron-1: `out_valid`=0, `out_last`=0, `busy`=0, index=0, return to COLLECT.
  - Any `in_valid` bit high in SEND is discarded (buffer and mask unchanged) and `drop_err` pulses the next cycle. This includes the final-transfer cycle, since the state there is still SEND.
  - Upstream is responsible for not producing the next frame until `busy` falls.
- numNeuron=1: each valid capture enters SEND with `out_last`=1 on the single element.
- Throughput: with `out_ready`=1, a frame takes numNeuron cycles in SEND. The next frame can be captured from the cycle after `out_last` transfers.
- No arithmetic; data passes bit-exact.

Test Plan:
- numNeuron=4, all `in_valid`=4'b1111 in one cycle with data {0x0004,0x0003,0x0002,0x0001} (neuron3..0), `out_ready`=1 -> next cycle `out_valid`=1. Then `out_data` 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, `out_last` on 0x0004, then `busy`=0.
- Staggered valids: bits 0,2 at cycle 0, bit 1 at cycle 3, bit 3 at cycle 5 -> `out_valid` first high at cycle 6, order by neuron index unchanged.
- Backpressure: `out_ready` toggles 1,0,0,1,... -> each element held stable while `out_ready`=0. Exactly 4 transfers, no loss or duplication.
- `in_valid[1]` pulses during SEND -> `drop_err` one-cycle pulse, streamed frame unchanged. The next frame collects normally afterwards.
- `in_valid[2]` pulses twice in COLLECT (0x00AA then 0x00BB) before the others -> `dup_err` pulse, element 2 output = 0x00BB.
- Assert `rstn` low mid-SEND at index 2 -> all outputs 0 immediately. After release, a fresh full frame streams from element 0 with no stale data.

Source files
------------

// File: rtl/layer_out_serializer_if.sv
// Bus bundle between a layer's neuron array, the serializer and the next layer's input.
interface layer_out_serializer_if #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
);
    logic [numNeuron*dataWidth-1:0] in_data;
    logic [numNeuron-1:0]           in_valid;
    logic [dataWidth-1:0]           out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic                           busy;
    logic                           drop_err;
    logic                           dup_err;

    // Producer/consumer side: drives neuron outputs and the stream ready.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, busy, drop_err, dup_err
    );

    // Serializer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, busy, drop_err, dup_err
    );
endinterface

// File: rtl/layer_out_serializer.sv
// Collects one value per neuron (each with its own valid), then streams the
// frame out serially, neuron 0 first, on a valid/ready interface.
module layer_out_serializer #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    layer_out_serializer_if.slave  bus
);
    localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam logic [IW-1:0]        LAST_IDX = IW'(numNeuron - 1);
    localparam logic [numNeuron-1:0] ALL_ONES = '1;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] SEND    = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [numNeuron-1:0] mask_q, mask_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [dataWidth-1:0] data_buf_q [numNeuron];
    logic [dataWidth-1:0] data_buf_d [numNeuron];
    logic [dataWidth-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 drop_err_q, drop_err_d;
    logic                 dup_err_q, dup_err_d;

    logic [IW-1:0]        idx_nxt;
    logic [numNeuron-1:0] seen;

    // Next-state: capture neuron outputs in COLLECT, step through the buffer in SEND.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        data_buf_d  = data_buf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        drop_err_d  = 1'b0;
        dup_err_d   = 1'b0;
        idx_nxt     = idx_q + IW'(1);
        seen        = mask_q | bus.in_valid;

        if (state_q == COLLECT) begin
            for (int i = 0; i < numNeuron; i++) begin
                if (bus.in_valid[i]) begin
                    data_buf_d[i] = bus.in_data[i*dataWidth +: dataWidth];
                end
            end
            // A neuron reporting twice keeps its latest value but is flagged.
            dup_err_d = |(bus.in_valid & mask_q);
            if (seen == ALL_ONES) begin
                // Element 0 comes from the updated buffer so a same-cycle arrival is used.
                mask_d      = '0;
                idx_d       = '0;
                state_d     = SEND;
                out_data_d  = data_buf_d[0];
                out_valid_d = 1'b1;
                out_last_d  = (numNeuron == 1);
            end else begin
                mask_d = seen;
            end
        end else begin
            // Arrivals while streaming would corrupt the frame; discard and flag them.
            drop_err_d = |bus.in_valid;
            if (bus.out_ready) begin
                if (idx_q == LAST_IDX) begin
                    state_d     = COLLECT;
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    idx_d      = idx_nxt;
                    out_data_d = data_buf_q[idx_nxt];
                    out_last_d = (idx_nxt == LAST_IDX);
                end
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            drop_err_q  <= 1'b0;
            dup_err_q   <= 1'b0;
            for (int i = 0; i < numNeuron; i++) begin
                data_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            drop_err_q  <= drop_err_d;
            dup_err_q   <= dup_err_d;
            data_buf_q  <= data_buf_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == SEND);
    assign bus.drop_err  = drop_err_q;
    assign bus.dup_err   = dup_err_q;
endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer with four neurons: directed frames checked
// against a frame-level model every cycle plus literal stream expectations.
module tb_layer_out_serializer;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    layer_out_serializer_if #(.numNeuron(N), .dataWidth(DW)) bus ();

    layer_out_serializer #(.numNeuron(N), .dataWidth(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the frame: values seen so far, which neurons reported, stream position.
    logic [DW-1:0] m_vals [N];
    bit            m_got  [N];
    bit            m_send;
    int            m_pos;
    bit            e_drop, e_dup;

    // Transfers observed on the stream.
    logic [DW-1:0] sq [$];
    bit            lq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_send = 0; m_pos = 0; e_drop = 0; e_dup = 0;
                for (int i = 0; i < N; i++) begin m_got[i] = 0; m_vals[i] = '0; end
            end else begin
                bit nd, nu;
                int cnt;
                nd = 0; nu = 0;
                if (m_send) begin
                    if (bus.in_valid != '0) nd = 1;
                    if (bus.out_ready) begin
                        if (m_pos == N - 1) begin m_send = 0; m_pos = 0; end
                        else m_pos++;
                    end
                end else begin
                    cnt = 0;
                    for (int i = 0; i < N; i++) begin
                        if (bus.in_valid[i]) begin
                            if (m_got[i]) nu = 1;
                            m_vals[i] = bus.in_data[i*DW +: DW];
                            m_got[i]  = 1;
                        end
                        if (m_got[i]) cnt++;
                    end
                    if (cnt == N) begin
                        m_send = 1; m_pos = 0;
                        for (int i = 0; i < N; i++) m_got[i] = 0;
                    end
                end
                e_drop = nd; e_dup = nu;
            end
        end
    end

    // Compare on the falling edge, and log each transfer that the next edge will make.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_out_data",  bus.out_data,  0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_out_last",  bus.out_last,  0);
                chk("rst_busy",      bus.busy,      0);
                chk("rst_drop_err",  bus.drop_err,  0);
                chk("rst_dup_err",   bus.dup_err,   0);
            end else begin
                chk("out_valid", bus.out_valid, m_send);
                chk("busy",      bus.busy,      m_send);
                chk("out_last",  bus.out_last,  (m_send && m_pos == N - 1));
                chk("drop_err",  bus.drop_err,  e_drop);
                chk("dup_err",   bus.dup_err,   e_dup);
                if (m_send) chk("out_data", bus.out_data, m_vals[m_pos]);
                if (bus.out_valid && bus.out_ready) begin
                    sq.push_back(bus.out_data);
                    lq.push_back(bus.out_last);
                end
            end
        end
    end

    // Present a set of valids for exactly one active edge; returns 1 unit after that edge.
    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = '0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((bus.busy || bus.out_valid) && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_timeout", (k < 60), 1);
    endtask

    task automatic check_stream(input string name, input logic [DW-1:0] e0, e1, e2, e3);
        logic [DW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        chk({name, "_count"}, sq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < sq.size()) begin
                chk({name, "_data"}, sq[k], ev[k]);
                chk({name, "_last"}, lq[k], (k == 3));
            end
        end
        sq.delete();
        lq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_lit", bus.out_valid, 0);
        chk("reset_data_lit",  bus.out_data,  0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // All four neurons in one cycle.
        sq.delete(); lq.delete();
        drive(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        chk("t1_valid_next_cycle", bus.out_valid, 1);
        chk("t1_first_data", bus.out_data, 16'h0001);
        wait_idle();
        chk("t1_busy_low", bus.busy, 0);
        check_stream("t1", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

        // Staggered arrivals: bits 0,2 at cycle 0, bit 1 at 3, bit 3 at 5.
        drive(4'b0101, {16'h0000, 16'h0012, 16'h0000, 16'h0010});
        drive(4'b0000, '0);
        drive(4'b0000, '0);
        drive(4'b0010, {16'h0000, 16'h0000, 16'h0011, 16'h0000});
        drive(4'b0000, '0);
        chk("t2_not_yet_valid", bus.out_valid, 0);
        drive(4'b1000, {16'h0013, 16'h0000, 16'h0000, 16'h0000});
        chk("t2_valid_cycle6", bus.out_valid, 1);
        wait_idle();
        check_stream("t2", 16'h0010, 16'h0011, 16'h0012, 16'h0013);

        // Backpressure with ready pattern 1,0,0,1.
        drive(4'b1111, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1});
        begin
            bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            int k = 0;
            while (bus.busy && k < 40) begin
                bus.out_ready = pat[k % 4];
                @(posedge clk); #1;
                k++;
            end
            chk("t3_timeout", (k < 40), 1);
        end
        bus.out_ready = 1'b1;
        check_stream("t3", 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);

        // Neuron 1 fires during SEND: dropped, frame unaffected.
        drive(4'b1111, {16'h0024, 16'h0023, 16'h0022, 16'h0021});
        drive(4'b0010, {16'h0000, 16'h0000, 16'hDEAD, 16'h0000});
        chk("t4_drop_pulse", bus.drop_err, 1);
        @(posedge clk); #1;
        chk("t4_drop_one_cycle", bus.drop_err, 0);
        wait_idle();
        check_stream("t4", 16'h0021, 16'h0022, 16'h0023, 16'h0024);
        // The dropped arrival must not count toward the next frame.
        drive(4'b1101, {16'h0034, 16'h0033, 16'h0000, 16'h0031});
        chk("t4_mask_clean", bus.out_valid, 0);
        drive(4'b0010, {16'h0000, 16'h0000, 16'h0032, 16'h0000});
        chk("t4_next_frame_valid", bus.out_valid, 1);
        wait_idle();
        check_stream("t4b", 16'h0031, 16'h0032, 16'h0033, 16'h0034);

        // Neuron 2 reports twice in COLLECT: latest value wins.
        drive(4'b0100, {16'h0000, 16'h00AA, 16'h0000, 16'h0000});
        drive(4'b0100, {16'h0000, 16'h00BB, 16'h0000, 16'h0000});
        chk("t5_dup_pulse", bus.dup_err, 1);
        drive(4'b1011, {16'h0054, 16'h00CC, 16'h0052, 16'h0051});
        chk("t5_dup_cleared", bus.dup_err, 0);
        wait_idle();
        check_stream("t5", 16'h0051, 16'h0052, 16'h00BB, 16'h0054);

        // Reset mid-SEND at index 2, then a fresh frame.
        drive(4'b1111, {16'h0064, 16'h0063, 16'h0062, 16'h0061});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_at_index2", bus.out_data, 16'h0063);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_data",  bus.out_data,  0);
        chk("t6_rst_busy",  bus.busy,      0);
        chk("t6_rst_last",  bus.out_last,  0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_partial", bus.out_valid, 0);
        sq.delete(); lq.delete();
        drive(4'b1111, {16'h0074, 16'h0073, 16'h0072, 16'h0071});
        chk("t6_fresh_first", bus.out_data, 16'h0071);
        wait_idle();
        check_stream("t6", 16'h0071, 16'h0072, 16'h0073, 16'h0074);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
